seq_stream_checker: RTL and testbench

- Downstream monitor for the 4-bit sequence counter.
- Samples the counter's output stream, synchronises to the repeating sequence 1,3,4,6,8,10,12,14,1,… and reports lock status.
- Flags every out-of-sequence value, keeps error and lap statistics, and raises a sticky fault when the error count reaches a limit.
- Sits between the counter and the status/debug register block.

---
 rtl/seq_stream_checker_if.sv | 28 ++
 rtl/seq_stream_checker.sv | 176 +++++++++++++++++
 tb/tb_seq_stream_checker.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/seq_stream_checker_if.sv
// Stream and status bundle between the sequence counter, the stream checker
// and the status register block.
interface seq_stream_checker_if #(
    parameter int ERR_W = 8,
    parameter int LAP_W = 8
);
    logic             in_valid;
    logic [3:0]       count_in;
    logic             clear;
    logic             locked;
    logic             err_pulse;
    logic             fault;
    logic [ERR_W-1:0] err_count;
    logic [LAP_W-1:0] lap_count;
    logic [3:0]       expected;

    // Drives the stream and the clear input, and observes the status.
    modport master (
        output in_valid, count_in, clear,
        input  locked, err_pulse, fault, err_count, lap_count, expected
    );

    // The checker itself.
    modport slave (
        input  in_valid, count_in, clear,
        output locked, err_pulse, fault, err_count, lap_count, expected
    );
endinterface

// File: rtl/seq_stream_checker.sv
// Monitors the 1,3,4,6,8,10,12,14 counter stream: hunts for a sync point,
// declares lock, flags out-of-sequence samples, and keeps error/lap statistics.
module seq_stream_checker #(
    parameter int LOCK_LEN  = 2,
    parameter int ERR_W     = 8,
    parameter int LAP_W     = 8,
    parameter int ERR_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    seq_stream_checker_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [3:0]       expected_q, expected_d;
    logic [3:0]       run_q, run_d;
    logic             locked_q, locked_d;
    logic             err_pulse_q, err_pulse_d;
    logic             fault_q, fault_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;
    logic [LAP_W-1:0] lap_count_q, lap_count_d;
    logic [3:0]       v_s;

    function automatic logic in_legal(input logic [3:0] v);
        logic r;
        case (v)
            4'd1, 4'd3, 4'd4, 4'd6, 4'd8, 4'd10, 4'd12, 4'd14: r = 1'b1;
            default:                                           r = 1'b0;
        endcase
        return r;
    endfunction

    // Illegal inputs never reach succ() through a state change; they map to 1.
    function automatic logic [3:0] succ(input logic [3:0] v);
        logic [3:0] r;
        case (v)
            4'd1:    r = 4'd3;
            4'd3:    r = 4'd4;
            4'd4:    r = 4'd6;
            4'd6:    r = 4'd8;
            4'd8:    r = 4'd10;
            4'd10:   r = 4'd12;
            4'd12:   r = 4'd14;
            4'd14:   r = 4'd1;
            default: r = 4'd1;
        endcase
        return r;
    endfunction

    assign v_s = bus.count_in;

    // Next-state, sequence tracking and statistics.
    always_comb begin
        state_d     = state_q;
        expected_d  = expected_q;
        run_d       = run_q;
        err_pulse_d = 1'b0;
        err_count_d = err_count_q;
        lap_count_d = lap_count_q;
        fault_d     = fault_q;
        if (bus.in_valid) begin
            case (state_q)
                ST_HUNT: begin
                    if (in_legal(v_s)) begin
                        state_d    = ST_SYNC;
                        expected_d = succ(v_s);
                        run_d      = 4'd0;
                    end else begin
                        state_d    = ST_HUNT;
                    end
                end
                ST_SYNC: begin
                    if (v_s == expected_q) begin
                        run_d      = run_q + 4'd1;
                        expected_d = succ(v_s);
                        if ({1'b0, run_q} + 5'd1 == 5'(LOCK_LEN)) begin
                            state_d = ST_LOCKED;
                        end else begin
                            state_d = ST_SYNC;
                        end
                    end else if (in_legal(v_s)) begin
                        expected_d = succ(v_s);
                        run_d      = 4'd0;
                    end else begin
                        state_d    = ST_HUNT;
                    end
                end
                ST_LOCKED: begin
                    if (v_s == expected_q) begin
                        expected_d = succ(v_s);
                        if (v_s == 4'd1) begin
                            lap_count_d = lap_count_q + {{(LAP_W-1){1'b0}}, 1'b1};
                        end else begin
                            lap_count_d = lap_count_q;
                        end
                    end else begin
                        err_pulse_d = 1'b1;
                        if (err_count_q != {ERR_W{1'b1}}) begin
                            err_count_d = err_count_q + {{(ERR_W-1){1'b0}}, 1'b1};
                        end else begin
                            err_count_d = err_count_q;
                        end
                        if (in_legal(v_s)) begin
                            state_d    = ST_SYNC;
                            expected_d = succ(v_s);
                            run_d      = 4'd0;
                        end else begin
                            state_d    = ST_HUNT;
                        end
                    end
                end
                default: begin
                    state_d    = ST_HUNT;
                    expected_d = 4'd1;
                    run_d      = 4'd0;
                end
            endcase
        end else begin
            state_d = state_q;
        end

        if (err_count_d >= ERR_W'(ERR_LIMIT)) begin
            fault_d = 1'b1;
        end else begin
            fault_d = fault_q;
        end

        // Clear overrides any same-cycle error count and fault update.
        if (bus.clear) begin
            err_count_d = {ERR_W{1'b0}};
            lap_count_d = {LAP_W{1'b0}};
            fault_d     = 1'b0;
        end else begin
            lap_count_d = lap_count_d;
        end

        locked_d = (state_d == ST_LOCKED);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_HUNT;
            expected_q  <= 4'd1;
            run_q       <= 4'd0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            fault_q     <= 1'b0;
            err_count_q <= {ERR_W{1'b0}};
            lap_count_q <= {LAP_W{1'b0}};
        end else begin
            state_q     <= state_d;
            expected_q  <= expected_d;
            run_q       <= run_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            fault_q     <= fault_d;
            err_count_q <= err_count_d;
            lap_count_q <= lap_count_d;
        end
    end

    assign bus.locked    = locked_q;
    assign bus.err_pulse = err_pulse_q;
    assign bus.fault     = fault_q;
    assign bus.err_count = err_count_q;
    assign bus.lap_count = lap_count_q;
    assign bus.expected  = expected_q;

endmodule

// File: tb/tb_seq_stream_checker.sv
// Directed bench for seq_stream_checker: lock-up, laps, error recovery,
// fault/clear/saturation, idle freeze and mid-run reset.
module tb_seq_stream_checker;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    seq_stream_checker_if #(.ERR_W(8), .LAP_W(8)) bus ();

    seq_stream_checker #(
        .LOCK_LEN (2),
        .ERR_W    (8),
        .LAP_W    (8),
        .ERR_LIMIT(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic send(input logic [3:0] v, input logic clr);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.count_in = v;
        bus.clear    = clr;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.clear    = 1'b0;
    endtask

    task automatic idle(input logic clr);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.count_in = 4'h5;
        bus.clear    = clr;
        @(posedge clk);
        #1;
        bus.clear    = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.count_in = 4'h0;
        bus.clear    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if (bus.expected !== 4'd1) begin n_fail++; $display("FAIL reset_expected got=%0d exp=1", bus.expected); end
        n_tests++; if ({bus.locked, bus.err_pulse, bus.fault} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got=%b exp=000", {bus.locked, bus.err_pulse, bus.fault}); end
        n_tests++; if ({bus.err_count, bus.lap_count} !== 16'h0000) begin n_fail++; $display("FAIL reset_counts got=%h exp=0000", {bus.err_count, bus.lap_count}); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_lock();
        send(4'd1, 1'b0);
        n_tests++; if (bus.locked !== 1'b0) begin n_fail++; $display("FAIL lock_after1 got=%b exp=0", bus.locked); end
        send(4'd3, 1'b0);
        n_tests++; if (bus.locked !== 1'b0) begin n_fail++; $display("FAIL lock_after3 got=%b exp=0", bus.locked); end
        send(4'd4, 1'b0);
        n_tests++; if (bus.locked !== 1'b1) begin n_fail++; $display("FAIL lock_after4 got=%b exp=1", bus.locked); end
        n_tests++; if (bus.expected !== 4'd6) begin n_fail++; $display("FAIL lock_expected got=%0d exp=6", bus.expected); end
        n_tests++; if (bus.err_count !== 8'd0) begin n_fail++; $display("FAIL lock_errcnt got=%0d exp=0", bus.err_count); end
    endtask

    task automatic test_lap();
        logic [3:0] seq_v [5] = '{4'd6, 4'd8, 4'd10, 4'd12, 4'd14};
        for (int i = 0; i < 5; i++) begin
            send(seq_v[i], 1'b0);
            n_tests++; if ({bus.err_pulse, bus.lap_count} !== 9'd0) begin n_fail++; $display("FAIL lap_pre%0d pulse/lap got=%b/%0d exp=0/0", i, bus.err_pulse, bus.lap_count); end
        end
        send(4'd1, 1'b0);
        n_tests++; if (bus.lap_count !== 8'd1) begin n_fail++; $display("FAIL lap_count got=%0d exp=1", bus.lap_count); end
        n_tests++; if (bus.expected !== 4'd3) begin n_fail++; $display("FAIL lap_expected got=%0d exp=3", bus.expected); end
        n_tests++; if ({bus.err_pulse, bus.locked} !== 2'b01) begin n_fail++; $display("FAIL lap_flags got=%b exp=01", {bus.err_pulse, bus.locked}); end
    endtask

    task automatic test_illegal_error();
        send(4'd3, 1'b0);
        send(4'd4, 1'b0);
        send(4'd6, 1'b0);
        send(4'd5, 1'b0);
        n_tests++; if (bus.err_pulse !== 1'b1) begin n_fail++; $display("FAIL ill_pulse got=%b exp=1", bus.err_pulse); end
        n_tests++; if (bus.err_count !== 8'd1) begin n_fail++; $display("FAIL ill_errcnt got=%0d exp=1", bus.err_count); end
        n_tests++; if (bus.locked !== 1'b0) begin n_fail++; $display("FAIL ill_locked got=%b exp=0", bus.locked); end
        n_tests++; if (bus.expected !== 4'd8) begin n_fail++; $display("FAIL ill_expected_hold got=%0d exp=8", bus.expected); end
        idle(1'b0);
        n_tests++; if (bus.err_pulse !== 1'b0) begin n_fail++; $display("FAIL ill_pulse_width got=%b exp=0", bus.err_pulse); end
        send(4'd8, 1'b0);
        send(4'd10, 1'b0);
        n_tests++; if (bus.locked !== 1'b0) begin n_fail++; $display("FAIL ill_relock_early got=%b exp=0", bus.locked); end
        send(4'd12, 1'b0);
        n_tests++; if ({bus.locked, bus.expected} !== {1'b1, 4'd14}) begin n_fail++; $display("FAIL ill_relock got=%b/%0d exp=1/14", bus.locked, bus.expected); end
    endtask

    task automatic test_legal_error();
        send(4'd14, 1'b0);
        send(4'd1, 1'b0);
        send(4'd3, 1'b0);
        send(4'd4, 1'b0);
        send(4'd6, 1'b0);
        send(4'd12, 1'b0);
        n_tests++; if ({bus.err_pulse, bus.locked} !== 2'b10) begin n_fail++; $display("FAIL leg_flags got=%b exp=10", {bus.err_pulse, bus.locked}); end
        n_tests++; if (bus.err_count !== 8'd2) begin n_fail++; $display("FAIL leg_errcnt got=%0d exp=2", bus.err_count); end
        n_tests++; if (bus.expected !== 4'd14) begin n_fail++; $display("FAIL leg_expected got=%0d exp=14", bus.expected); end
        send(4'd14, 1'b0);
        n_tests++; if ({bus.err_pulse, bus.locked} !== 2'b00) begin n_fail++; $display("FAIL leg_sync got=%b exp=00", {bus.err_pulse, bus.locked}); end
        send(4'd1, 1'b0);
        n_tests++; if ({bus.locked, bus.expected} !== {1'b1, 4'd3}) begin n_fail++; $display("FAIL leg_relock got=%b/%0d exp=1/3", bus.locked, bus.expected); end
        n_tests++; if (bus.lap_count !== 8'd2) begin n_fail++; $display("FAIL leg_lap got=%0d exp=2", bus.lap_count); end
    endtask

    task automatic err_and_relock();
        send(4'd0, 1'b0);
        send(4'd1, 1'b0);
        send(4'd3, 1'b0);
        send(4'd4, 1'b0);
    endtask

    task automatic test_fault_clear_sat();
        err_and_relock();
        n_tests++; if ({bus.err_count, bus.fault} !== {8'd3, 1'b0}) begin n_fail++; $display("FAIL flt_3err got=%0d/%b exp=3/0", bus.err_count, bus.fault); end
        err_and_relock();
        n_tests++; if ({bus.err_count, bus.fault} !== {8'd4, 1'b1}) begin n_fail++; $display("FAIL flt_4err got=%0d/%b exp=4/1", bus.err_count, bus.fault); end
        idle(1'b1);
        n_tests++; if ({bus.err_count, bus.fault, bus.locked} !== {8'd0, 1'b0, 1'b1}) begin n_fail++; $display("FAIL flt_clear cnt/fault/locked got=%0d/%b/%b exp=0/0/1", bus.err_count, bus.fault, bus.locked); end
        n_tests++; if ({bus.lap_count, bus.expected} !== {8'd0, 4'd6}) begin n_fail++; $display("FAIL flt_clear lap/exp got=%0d/%0d exp=0/6", bus.lap_count, bus.expected); end
        for (int i = 0; i < 260; i++) err_and_relock();
        n_tests++; if ({bus.err_count, bus.fault} !== {8'd255, 1'b1}) begin n_fail++; $display("FAIL flt_saturate got=%0d/%b exp=255/1", bus.err_count, bus.fault); end
        send(4'd0, 1'b1);
        n_tests++; if ({bus.err_pulse, bus.err_count, bus.fault} !== {1'b1, 8'd0, 1'b0}) begin n_fail++; $display("FAIL flt_clear_vs_err got=%b/%0d/%b exp=1/0/0", bus.err_pulse, bus.err_count, bus.fault); end
        n_tests++; if ({bus.locked, bus.expected} !== {1'b0, 4'd6}) begin n_fail++; $display("FAIL flt_clear_state got=%b/%0d exp=0/6", bus.locked, bus.expected); end
    endtask

    task automatic test_idle_and_reset();
        send(4'd1, 1'b0);
        send(4'd3, 1'b0);
        send(4'd4, 1'b0);
        send(4'd6, 1'b0);
        for (int i = 0; i < 5; i++) begin
            idle(1'b0);
            n_tests++; if ({bus.locked, bus.err_pulse, bus.expected, bus.err_count, bus.lap_count} !== {1'b1, 1'b0, 4'd8, 8'd0, 8'd0}) begin
                n_fail++; $display("FAIL idle_freeze%0d lk/pl/exp/err/lap got=%b/%b/%0d/%0d/%0d exp=1/0/8/0/0", i, bus.locked, bus.err_pulse, bus.expected, bus.err_count, bus.lap_count);
            end
        end
        send(4'd8, 1'b0);
        send(4'd9, 1'b0);
        n_tests++; if (bus.err_count !== 8'd1) begin n_fail++; $display("FAIL rst_pre_err got=%0d exp=1", bus.err_count); end
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        n_tests++; if ({bus.locked, bus.err_pulse, bus.fault, bus.expected, bus.err_count, bus.lap_count} !== {3'b000, 4'd1, 8'd0, 8'd0}) begin
            n_fail++; $display("FAIL rst_async got=%b/%0d/%0d/%0d exp=000/1/0/0", {bus.locked, bus.err_pulse, bus.fault}, bus.expected, bus.err_count, bus.lap_count);
        end
        @(negedge clk);
        reset = 1'b0;
        send(4'd15, 1'b0);
        n_tests++; if ({bus.err_pulse, bus.locked} !== 2'b00) begin n_fail++; $display("FAIL start_junk1 got=%b exp=00", {bus.err_pulse, bus.locked}); end
        send(4'd12, 1'b0);
        n_tests++; if ({bus.err_pulse, bus.locked, bus.expected} !== {2'b00, 4'd14}) begin n_fail++; $display("FAIL start_junk2 got=%b/%0d exp=00/14", {bus.err_pulse, bus.locked}, bus.expected); end
        send(4'd1, 1'b0);
        n_tests++; if ({bus.err_pulse, bus.locked} !== 2'b00) begin n_fail++; $display("FAIL start_1 got=%b exp=00", {bus.err_pulse, bus.locked}); end
        send(4'd3, 1'b0);
        n_tests++; if ({bus.err_pulse, bus.locked} !== 2'b00) begin n_fail++; $display("FAIL start_3 got=%b exp=00", {bus.err_pulse, bus.locked}); end
        send(4'd4, 1'b0);
        n_tests++; if ({bus.err_pulse, bus.locked, bus.err_count} !== {2'b01, 8'd0}) begin n_fail++; $display("FAIL start_4 got=%b/%0d exp=01/0", {bus.err_pulse, bus.locked}, bus.err_count); end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_lock();
        test_lap();
        test_illegal_error();
        test_legal_error();
        test_fault_clear_sat();
        test_idle_and_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
